nubus_master_arbiter: RTL and testbench

// - N-channel front end for the single NuBus master (cpu_*) port; lets several on-card requesters share it.
// - Round-robin arbitration, per-channel lock hold, transaction timeout with error return.
// - Sits between requesters (CPU, DMA, ...) and nubus master; master side unchanged.

---
 rtl/nubus_arb_pkg.sv | 19 +
 rtl/nubus_rr_pick.sv | 31 +++
 rtl/nubus_master_arbiter.sv | 148 ++++++++++++++
 tb/tb_nubus_master_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nubus_arb_pkg.sv
// Shared types and constants for the NuBus master-port arbiter.
package nubus_arb_pkg;

  localparam int unsigned AD_W   = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE,
    LOCKED
  } arb_state_t;

  // Low bit of channel idx inside a packed per-channel bus of slices w bits wide.
  function automatic int unsigned ch_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/nubus_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping.
module nubus_rr_pick #(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_last,
  output logic [NUM_CH-1:0] o_grant,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    // k = NUM_CH revisits i_last itself, so a lone repeat requester is still served.
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      w_pos = IDX_W'((32'(i_last) + k) % NUM_CH);
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/nubus_master_arbiter.sv
// N-channel round-robin front end sharing one NuBus master port, with lock hold and timeout.
module nubus_master_arbiter
  import nubus_arb_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned TIMEOUT_CLOCKS = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic                     nub_clkn,
  input  logic                     nub_resetn,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*AD_W-1:0]   ch_addr,
  input  logic [NUM_CH*AD_W-1:0]   ch_wdata,
  input  logic [NUM_CH*STRB_W-1:0] ch_write,
  input  logic [NUM_CH-1:0]        ch_lock,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [NUM_CH-1:0]        ch_err,
  output logic [AD_W-1:0]          ch_rdata,
  output logic                     cpu_valid,
  output logic [AD_W-1:0]          cpu_addr,
  output logic [AD_W-1:0]          cpu_wdata,
  output logic [STRB_W-1:0]        cpu_write,
  output logic                     cpu_lock,
  input  logic                     cpu_ready,
  input  logic [AD_W-1:0]          cpu_rdata
);

  localparam int unsigned      IDX_W   = $clog2(NUM_CH);
  localparam logic             TO_EN   = (TIMEOUT_CLOCKS != 0);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CLOCKS - 1);

  arb_state_t        r_state;
  logic [IDX_W-1:0]  r_rr;
  logic [IDX_W-1:0]  r_grant;
  logic [NUM_CH-1:0] r_grant_oh;
  logic              r_lock;
  logic [TO_W-1:0]   r_cnt;

  logic [NUM_CH-1:0] w_grant_oh;
  logic [IDX_W-1:0]  w_idx;
  logic              w_any;
  logic [IDX_W-1:0]  w_sel;
  logic [AD_W-1:0]   w_addr;
  logic [AD_W-1:0]   w_wdata;
  logic [STRB_W-1:0] w_strb;
  logic              w_lock;

  nubus_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .i_req   (ch_valid),
    .i_last  (r_rr),
    .o_grant (w_grant_oh),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // IDLE latches the picker's choice; LOCKED re-latches the held channel.
  always_comb begin
    w_sel   = (r_state == LOCKED) ? r_grant : w_idx;
    w_addr  = ch_addr[ch_lo(32'(w_sel), AD_W) +: AD_W];
    w_wdata = ch_wdata[ch_lo(32'(w_sel), AD_W) +: AD_W];
    w_strb  = ch_write[ch_lo(32'(w_sel), STRB_W) +: STRB_W];
    w_lock  = ch_lock[w_sel];
  end

  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      r_state    <= IDLE;
      r_rr       <= IDX_W'(NUM_CH - 1);
      r_grant    <= '0;
      r_grant_oh <= '0;
      r_lock     <= 1'b0;
      r_cnt      <= '0;
      ch_ready   <= '0;
      ch_err     <= '0;
      ch_rdata   <= '0;
      cpu_valid  <= 1'b0;
      cpu_addr   <= '0;
      cpu_wdata  <= '0;
      cpu_write  <= '0;
      cpu_lock   <= 1'b0;
    end else begin
      ch_ready <= '0;
      ch_err   <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            cpu_addr   <= w_addr;
            cpu_wdata  <= w_wdata;
            cpu_write  <= w_strb;
            cpu_lock   <= w_lock;
            r_lock     <= w_lock;
            cpu_valid  <= 1'b1;
            r_rr       <= w_idx;
            r_grant    <= w_idx;
            r_grant_oh <= w_grant_oh;
            r_cnt      <= '0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (cpu_ready) begin
            ch_ready  <= r_grant_oh;
            ch_rdata  <= cpu_rdata;
            cpu_valid <= 1'b0;
            r_cnt     <= '0;
            r_state   <= RELEASE;
          end else if (TO_EN && (r_cnt == TO_LAST)) begin
            ch_ready  <= r_grant_oh;
            ch_err    <= r_grant_oh;
            ch_rdata  <= '0;
            cpu_valid <= 1'b0;
            r_cnt     <= '0;
            r_state   <= RELEASE;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        RELEASE: begin
          if (!cpu_ready) begin
            if (r_lock) begin
              r_state <= LOCKED;
            end else begin
              cpu_lock <= 1'b0;
              r_state  <= IDLE;
            end
          end
        end
        LOCKED: begin
          // cpu_lock stays up through this transaction; RELEASE drops it if the new lock bit is 0.
          if (ch_valid[r_grant]) begin
            cpu_addr  <= w_addr;
            cpu_wdata <= w_wdata;
            cpu_write <= w_strb;
            r_lock    <= w_lock;
            cpu_valid <= 1'b1;
            r_cnt     <= '0;
            r_state   <= BUSY;
          end else if (!ch_lock[r_grant]) begin
            cpu_lock <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nubus_master_arbiter.sv
// Directed bench: arbiter driving a small wait-state memory slave on the cpu_* side.
module tb_nubus_master_arbiter;

  localparam int WAIT = 1;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [3:0]   ch_valid;
  logic [127:0] ch_addr;
  logic [127:0] ch_wdata;
  logic [15:0]  ch_write;
  logic [3:0]   ch_lock;
  logic [3:0]   ch_ready;
  logic [3:0]   ch_err;
  logic [31:0]  ch_rdata;
  logic         cpu_valid;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_write;
  logic         cpu_lock;
  logic         cpu_ready;
  logic [31:0]  cpu_rdata;

  bit   [31:0]  mem [64];
  logic         stall;
  int           wcnt;

  int n_cmp = 0;
  int n_bad = 0;

  int          g_ord [4];
  int          g_n;
  logic [31:0] g_rd [4];
  logic [3:0]  g_err;
  int          g_vrise;
  int          g_rdy;
  logic        g_fv;
  logic [31:0] g_fa;

  always #75 clk = ~clk;

  nubus_master_arbiter #(.NUM_CH(4), .TIMEOUT_CLOCKS(16), .TO_W(8)) dut (
    .nub_clkn   (clk),
    .nub_resetn (resetn),
    .ch_valid   (ch_valid),
    .ch_addr    (ch_addr),
    .ch_wdata   (ch_wdata),
    .ch_write   (ch_write),
    .ch_lock    (ch_lock),
    .ch_ready   (ch_ready),
    .ch_err     (ch_err),
    .ch_rdata   (ch_rdata),
    .cpu_valid  (cpu_valid),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_write  (cpu_write),
    .cpu_lock   (cpu_lock),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata)
  );

  // Memory slave: WAIT idle clocks after seeing cpu_valid, then a one-clock cpu_ready.
  always @(posedge clk) begin
    if (!resetn || stall || !cpu_valid) begin
      cpu_ready <= 1'b0;
      wcnt      <= 0;
    end else if (cpu_ready) begin
      cpu_ready <= 1'b0;
    end else if (wcnt == WAIT) begin
      cpu_ready <= 1'b1;
      wcnt      <= 0;
      cpu_rdata <= mem[cpu_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (cpu_write[b]) mem[cpu_addr[7:2]][b*8 +: 8] <= cpu_wdata[b*8 +: 8];
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  initial begin
    #(150 * 30000);
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int ch, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic lk);
    ch_addr[ch*32 +: 32] = a;
    ch_wdata[ch*32 +: 32] = d;
    ch_write[ch*4 +: 4] = s;
    ch_lock[ch] = lk;
  endtask

  // Raise the channels in mask and collect completions in arrival order (bounded).
  task automatic serve(input logic [3:0] mask);
    int need;
    need = $countones(mask);
    g_n = 0; g_vrise = -1; g_rdy = -1; g_err = '0;
    ch_valid = ch_valid | mask;
    for (int cyc = 1; cyc <= 400 && g_n < need; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin g_fv = cpu_valid; g_fa = cpu_addr; end
      if (g_vrise < 0 && cpu_valid) g_vrise = cyc;
      for (int i = 0; i < 4; i++) begin
        if (ch_ready[i]) begin
          if (g_n < 4) g_ord[g_n] = i;
          g_n++;
          g_rd[i] = ch_rdata;
          g_err[i] = ch_err[i];
          g_rdy = cyc;
          ch_valid[i] = 1'b0;
        end
      end
    end
    ch_valid = ch_valid & ~mask;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({cpu_valid, cpu_lock, ch_ready, ch_err} !== 10'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h want 000", {cpu_valid, cpu_lock, ch_ready, ch_err}); end
    n_cmp++; if ((cpu_addr | cpu_wdata | ch_rdata | {28'h0, cpu_write}) !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 00000000", cpu_addr | cpu_wdata | ch_rdata | {28'h0, cpu_write}); end
    resetn = 1'b1;
  endtask

  task automatic test_single();
    set_req(0, 32'hF000_0000, 32'h8765_4321, 4'b1111, 1'b0);
    serve(4'b0001);
    n_cmp++; if (g_fv !== 1'b1) begin n_bad++; $display("FAIL single_valid_latency: got %b want 1", g_fv); end
    n_cmp++; if (g_fa !== 32'hF000_0000) begin n_bad++; $display("FAIL single_addr: got %h want f0000000", g_fa); end
    n_cmp++; if (g_n !== 1 || g_err !== 4'b0000) begin n_bad++; $display("FAIL single_write: got n=%0d err=%b want n=1 err=0000", g_n, g_err); end
    n_cmp++; if (g_rdy !== 4) begin n_bad++; $display("FAIL single_ready_latency: got %0d want 4", g_rdy); end
    set_req(0, 32'hF000_0000, 32'h0, 4'b0000, 1'b0);
    serve(4'b0001);
    n_cmp++; if (g_n !== 1 || g_rd[0] !== 32'h8765_4321 || g_err[0] !== 1'b0) begin n_bad++; $display("FAIL single_read: got n=%0d rdata=%h err=%b want 1 87654321 0", g_n, g_rd[0], g_err[0]); end
  endtask

  task automatic test_contention();
    int exp2 [4] = '{2, 3, 0, 1};
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'hF000_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'b1111, 1'b0);
    serve(4'b1111);
    n_cmp++; if (g_n !== 4) begin n_bad++; $display("FAIL contention_count: got %0d want 4", g_n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (g_ord[i] !== i) begin n_bad++; $display("FAIL contention_order[%0d]: got %0d want %0d", i, g_ord[i], i); end
    end
    set_req(1, 32'hF000_0004, 32'h0, 4'b0000, 1'b0);
    serve(4'b0010);
    n_cmp++; if (g_rd[1] !== 32'hA000_0001) begin n_bad++; $display("FAIL contention_ch1_read: got %h want a0000001", g_rd[1]); end
    for (int i = 0; i < 4; i++) set_req(i, 32'hF000_0000 + 32'(4 * i), 32'h0, 4'b0000, 1'b0);
    serve(4'b1111);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (g_ord[i] !== exp2[i]) begin n_bad++; $display("FAIL rr_round2_order[%0d]: got %0d want %0d", i, g_ord[i], exp2[i]); end
      n_cmp++; if (g_rd[i] !== 32'hA000_0000 + 32'(i)) begin n_bad++; $display("FAIL rr_round2_rdata[%0d]: got %h want %h", i, g_rd[i], 32'hA000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_lock();
    int   n2 = 0;
    int   hold = 0;
    logic l_drop = 1'b0;
    logic rel = 1'b0;
    logic early = 1'b0;
    logic got1 = 1'b0;
    logic reraise = 1'b0;
    logic [31:0] rd1 = '0;
    logic lk1 = 1'b1;
    set_req(2, 32'hF000_0004, 32'h0, 4'b0000, 1'b1);
    set_req(1, 32'hF000_0008, 32'h0, 4'b0000, 1'b0);
    ch_valid[2] = 1'b1;
    @(posedge clk); #1;
    ch_valid[1] = 1'b1;
    for (int cyc = 0; cyc < 400 && !got1; cyc++) begin
      @(posedge clk); #1;
      if (!rel && cpu_lock !== 1'b1) l_drop = 1'b1;
      if (reraise) begin ch_valid[2] = 1'b1; reraise = 1'b0; end
      if (ch_ready[2]) begin
        n2++;
        n_cmp++; if (ch_rdata !== 32'hA000_0000 + 32'(n2)) begin n_bad++; $display("FAIL lock_read%0d: got %h want %h", n2, ch_rdata, 32'hA000_0000 + 32'(n2)); end
        ch_valid[2] = 1'b0;
        if (n2 < 3) begin set_req(2, 32'hF000_0004 + 32'(4 * n2), 32'h0, 4'b0000, 1'b1); reraise = 1'b1; end
      end
      if (ch_ready[1]) begin got1 = 1'b1; rd1 = ch_rdata; lk1 = cpu_lock; ch_valid[1] = 1'b0; if (!rel) early = 1'b1; end
      if (n2 == 3 && !rel) begin hold++; if (hold == 6) begin ch_lock[2] = 1'b0; rel = 1'b1; end end
    end
    ch_valid = '0;
    n_cmp++; if (n2 !== 3) begin n_bad++; $display("FAIL lock_ch2_count: got %0d want 3", n2); end
    n_cmp++; if (l_drop !== 1'b0) begin n_bad++; $display("FAIL lock_held: cpu_lock dropped=%b want 0", l_drop); end
    n_cmp++; if (got1 !== 1'b1 || early !== 1'b0) begin n_bad++; $display("FAIL lock_ch1_after_release: got served=%b early=%b want 1 0", got1, early); end
    n_cmp++; if (rd1 !== 32'hA000_0002 || lk1 !== 1'b0) begin n_bad++; $display("FAIL lock_ch1_read: got %h lock=%b want a0000002 0", rd1, lk1); end
  endtask

  task automatic test_timeout();
    stall = 1'b1;
    set_req(3, 32'hF000_0008, 32'h0, 4'b0000, 1'b0);
    serve(4'b1000);
    stall = 1'b0;
    n_cmp++; if (g_n !== 1 || g_err !== 4'b1000) begin n_bad++; $display("FAIL timeout_err: got n=%0d err=%b want 1 1000", g_n, g_err); end
    n_cmp++; if (g_rd[3] !== 32'h0) begin n_bad++; $display("FAIL timeout_rdata: got %h want 00000000", g_rd[3]); end
    n_cmp++; if (g_rdy - g_vrise !== 16) begin n_bad++; $display("FAIL timeout_clocks: got %0d want 16", g_rdy - g_vrise); end
  endtask

  task automatic test_byte_lanes();
    set_req(1, 32'hF000_0014, 32'h8765_4321, 4'b0100, 1'b0);
    serve(4'b0010);
    n_cmp++; if (g_n !== 1 || g_err[1] !== 1'b0) begin n_bad++; $display("FAIL lanes_write: got n=%0d err=%b want 1 0", g_n, g_err[1]); end
    set_req(1, 32'hF000_0014, 32'h0, 4'b0000, 1'b0);
    serve(4'b0010);
    n_cmp++; if (g_rd[1] !== 32'h0065_0000) begin n_bad++; $display("FAIL lanes_read: got %h want 00650000", g_rd[1]); end
  endtask

  task automatic test_reset_mid_busy();
    logic seen = 1'b0;
    logic stray = 1'b0;
    stall = 1'b1;
    set_req(0, 32'hF000_0000, 32'h0, 4'b0000, 1'b0);
    ch_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(posedge clk); #1;
      seen = cpu_valid;
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL midrst_busy: cpu_valid got %b want 1", seen); end
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({cpu_valid, cpu_lock, ch_ready, ch_err} !== 10'h0) begin n_bad++; $display("FAIL midrst_ctrl: got %h want 000", {cpu_valid, cpu_lock, ch_ready, ch_err}); end
    n_cmp++; if (cpu_addr !== 32'h0) begin n_bad++; $display("FAIL midrst_addr: got %h want 00000000", cpu_addr); end
    ch_valid = '0;
    resetn = 1'b1;
    stall = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clk); #1;
      if (ch_ready !== 4'b0000) stray = 1'b1;
    end
    n_cmp++; if (stray !== 1'b0) begin n_bad++; $display("FAIL midrst_no_ready: got stray=%b want 0", stray); end
    set_req(0, 32'hF000_0000, 32'h0, 4'b0000, 1'b0);
    set_req(1, 32'hF000_0004, 32'h0, 4'b0000, 1'b0);
    serve(4'b0011);
    n_cmp++; if (g_n !== 2 || g_ord[0] !== 0) begin n_bad++; $display("FAIL midrst_first_grant: got n=%0d first=%0d want 2 0", g_n, g_ord[0]); end
  endtask

  initial begin
    ch_valid = '0; ch_addr = '0; ch_wdata = '0; ch_write = '0; ch_lock = '0;
    stall = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_timeout();
    test_byte_lanes();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
